// File: rtl/csc_sort_pkg.sv
// Shared definitions for the chamber-wide best-pattern scheduler.
//   MXCFEB   number of CFEBs scanned
//   MXCFEBB  CFEB index width
//   MXPATB   pattern width: [6:4] hit count, [3:0] pattern id, lsb = bend direction
//   MXKEYB   1/2-strip key width inside one CFEB
//   MXHSB    chamber 1/2-strip width ({cfeb,key})
package csc_sort_pkg;

  localparam int MXCFEB  = 7;
  localparam int MXCFEBB = 3;
  localparam int MXPATB  = 7;
  localparam int MXKEYB  = 5;
  localparam int MXHSB   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  // Quality rank of a pattern: the bend-direction lsb never takes part.
  function automatic logic [MXPATB-2:0] pat_rank(input logic [MXPATB-1:0] pat);
    return pat[MXPATB-1:1];
  endfunction

endpackage

// File: rtl/cfeb_next_en.sv
// Lowest-set-bit finder over the remaining-CFEB mask.
//   mask_i  remaining enabled CFEBs
//   idx_o   index of the lowest set bit (0 when mask_i is empty)
//   any_o   at least one CFEB remains
module cfeb_next_en
  import csc_sort_pkg::*;
(
  input  logic [MXCFEB-1:0]  mask_i,
  output logic [MXCFEBB-1:0] idx_o,
  output logic               any_o
);

  always_comb begin
    idx_o = '0;
    any_o = |mask_i;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = MXCFEB - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = MXCFEBB'(i);
    end
  end

endmodule

// File: rtl/cfeb_best_scheduler.sv
// Time-multiplexes one shared best-1-of-32 sorter across the CFEBs of a chamber.
// On start it issues every enabled CFEB to the sorter input mux (ascending, one per
// clock), tracks the best returned pattern across CFEBs and reports the chamber-wide
// best pattern and 1/2-strip with a one-clock done pulse.
//   clock, reset_n           clock, asynchronous active-low reset
//   start, cfeb_en           scan request and CFEB enable mask (latched on accept)
//   sort_sel, sort_vld       sorter input mux select and issue strobe
//   sort_pat, sort_key       sorter result, SORT_LATENCY clocks after issue
//   busy, done               scan in progress / results-valid pulse
//   best_vld, best_pat,
//   best_hs, best_cfeb       chamber best, held until the next accepted start
module cfeb_best_scheduler
  import csc_sort_pkg::*;
#(
  parameter int SORT_LATENCY = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [MXCFEB-1:0]  cfeb_en,
  output logic [MXCFEBB-1:0] sort_sel,
  output logic               sort_vld,
  input  logic [MXPATB-1:0]  sort_pat,
  input  logic [MXKEYB-1:0]  sort_key,
  output logic               busy,
  output logic               done,
  output logic               best_vld,
  output logic [MXPATB-1:0]  best_pat,
  output logic [MXHSB-1:0]   best_hs,
  output logic [MXCFEBB-1:0] best_cfeb
);

  sched_state_e state_q, state_d;

  logic [MXCFEB-1:0]  rem_q, rem_d;
  logic [MXCFEBB-1:0] sel_hold_q;
  logic [MXCFEBB-1:0] nxt_idx;
  logic               nxt_any;
  logic               accept;
  logic               issue;
  logic               last_issue;

  logic [SORT_LATENCY-1:0] stage_vld;
  logic [MXCFEBB-1:0]      stage_sel [SORT_LATENCY];
  logic                    ret_vld;
  logic [MXCFEBB-1:0]      ret_sel;
  logic                    drain_last;

  logic [MXPATB-1:0]  acc_pat_q, acc_pat_d;
  logic [MXCFEBB-1:0] acc_cfeb_q, acc_cfeb_d;
  logic [MXKEYB-1:0]  acc_key_q, acc_key_d;

  logic               best_vld_q;
  logic [MXPATB-1:0]  best_pat_q;
  logic [MXHSB-1:0]   best_hs_q;
  logic [MXCFEBB-1:0] best_cfeb_q;

  cfeb_next_en u_next_en (
    .mask_i (rem_q),
    .idx_o  (nxt_idx),
    .any_o  (nxt_any)
  );

  assign accept     = (state_q == ST_IDLE) && start;
  assign issue      = (state_q == ST_ISSUE) && nxt_any;
  assign rem_d      = rem_q & ~(MXCFEB'(1) << nxt_idx);
  assign last_issue = issue && (rem_d == '0);

  // Return pipe: tracks which CFEB each sorter result belongs to.
  for (genvar g = 0; g < SORT_LATENCY; g++) begin : g_ret
    logic               vld_q;
    logic [MXCFEBB-1:0] sel_q;
    logic               vld_in;
    logic [MXCFEBB-1:0] sel_in;

    if (g == 0) begin : g_head
      assign vld_in = sort_vld;
      assign sel_in = sort_sel;
    end else begin : g_tail
      assign vld_in = stage_vld[g-1];
      assign sel_in = stage_sel[g-1];
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        vld_q <= 1'b0;
        sel_q <= '0;
      end else begin
        vld_q <= vld_in;
        sel_q <= sel_in;
      end
    end

    assign stage_vld[g] = vld_q;
    assign stage_sel[g] = sel_q;
  end

  assign ret_vld = stage_vld[SORT_LATENCY-1];
  assign ret_sel = stage_sel[SORT_LATENCY-1];

  // The last return is consumed on the coming edge once nothing sits in the
  // earlier stages; an empty pipe (no CFEB enabled) drains in one clock.
  if (SORT_LATENCY == 1) begin : g_drain1
    assign drain_last = 1'b1;
  end else begin : g_drainn
    assign drain_last = ~|stage_vld[SORT_LATENCY-2:0];
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (|cfeb_en) ? ST_ISSUE : ST_DRAIN;
      ST_ISSUE: if (last_issue || !nxt_any) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    sort_vld = issue;
    sort_sel = issue ? nxt_idx : sel_hold_q;
    busy     = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    done     = (state_q == ST_DONE);
  end

  // Accumulator: strictly better rank replaces, so ties keep the lower CFEB.
  always_comb begin
    acc_pat_d  = acc_pat_q;
    acc_cfeb_d = acc_cfeb_q;
    acc_key_d  = acc_key_q;
    if (accept) begin
      acc_pat_d  = '0;
      acc_cfeb_d = '0;
      acc_key_d  = '0;
    end else if (ret_vld && (pat_rank(sort_pat) > pat_rank(acc_pat_q))) begin
      acc_pat_d  = sort_pat;
      acc_cfeb_d = ret_sel;
      acc_key_d  = sort_key;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rem_q       <= '0;
      sel_hold_q  <= '0;
      acc_pat_q   <= '0;
      acc_cfeb_q  <= '0;
      acc_key_q   <= '0;
      best_vld_q  <= 1'b0;
      best_pat_q  <= '0;
      best_hs_q   <= '0;
      best_cfeb_q <= '0;
    end else begin
      acc_pat_q  <= acc_pat_d;
      acc_cfeb_q <= acc_cfeb_d;
      acc_key_q  <= acc_key_d;
      if (accept) begin
        rem_q <= cfeb_en;
      end else if (issue) begin
        rem_q      <= rem_d;
        sel_hold_q <= nxt_idx;
      end
      if (accept) begin
        best_vld_q  <= 1'b0;
        best_pat_q  <= '0;
        best_hs_q   <= '0;
        best_cfeb_q <= '0;
      end else if ((state_q == ST_DRAIN) && drain_last) begin
        // Load from the next-state value so the final return is included.
        best_vld_q  <= |pat_rank(acc_pat_d);
        best_pat_q  <= acc_pat_d;
        best_hs_q   <= {acc_cfeb_d, acc_key_d};
        best_cfeb_q <= acc_cfeb_d;
      end
    end
  end

  assign best_vld  = best_vld_q;
  assign best_pat  = best_pat_q;
  assign best_hs   = best_hs_q;
  assign best_cfeb = best_cfeb_q;

endmodule

// File: tb/tb_cfeb_best_scheduler.sv
module tb_cfeb_best_scheduler;

  localparam int WIN = 20;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] cfeb_en = 7'd0;

  always #5 clock = ~clock;

  logic [2:0] sel1, sel3;
  logic       svld1, svld3;
  logic [6:0] spat1, spat3;
  logic [4:0] skey1, skey3;
  logic       busy1, busy3, done1, done3, bvld1, bvld3;
  logic [6:0] bpat1, bpat3;
  logic [7:0] bhs1, bhs3;
  logic [2:0] bcfeb1, bcfeb3;

  cfeb_best_scheduler #(.SORT_LATENCY(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start), .cfeb_en(cfeb_en),
    .sort_sel(sel1), .sort_vld(svld1), .sort_pat(spat1), .sort_key(skey1),
    .busy(busy1), .done(done1), .best_vld(bvld1), .best_pat(bpat1),
    .best_hs(bhs1), .best_cfeb(bcfeb1)
  );

  cfeb_best_scheduler #(.SORT_LATENCY(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .start(start), .cfeb_en(cfeb_en),
    .sort_sel(sel3), .sort_vld(svld3), .sort_pat(spat3), .sort_key(skey3),
    .busy(busy3), .done(done3), .best_vld(bvld3), .best_pat(bpat3),
    .best_hs(bhs3), .best_cfeb(bcfeb3)
  );

  // Per-CFEB best results the shared sorter would produce.
  logic [6:0] tab_pat [7];
  logic [4:0] tab_key [7];

  // Sorter models: results appear SORT_LATENCY clocks after issue; outside
  // valid slots they carry random junk that the scheduler must ignore.
  logic [15:0] garb = 16'd0;
  logic        p1_vld = 1'b0;
  logic [2:0]  p1_sel = 3'd0;
  logic        p3_vld [3] = '{1'b0, 1'b0, 1'b0};
  logic [2:0]  p3_sel [3] = '{3'd0, 3'd0, 3'd0};

  always @(posedge clock) begin
    garb      <= 16'($urandom);
    p1_vld    <= svld1;
    p1_sel    <= sel1;
    p3_vld[0] <= svld3;
    p3_sel[0] <= sel3;
    p3_vld[1] <= p3_vld[0];
    p3_sel[1] <= p3_sel[0];
    p3_vld[2] <= p3_vld[1];
    p3_sel[2] <= p3_sel[1];
  end

  assign spat1 = p1_vld    ? tab_pat[p1_sel]    : garb[6:0];
  assign skey1 = p1_vld    ? tab_key[p1_sel]    : garb[11:7];
  assign spat3 = p3_vld[2] ? tab_pat[p3_sel[2]] : garb[13:7];
  assign skey3 = p3_vld[2] ? tab_key[p3_sel[2]] : garb[15:11];

  int checks = 0;
  int errors = 0;

  // Result word: {vld, pat[6:0], cfeb[2:0], hs[7:0]}
  typedef logic [18:0] res_t;

  int          dk1, dk3, dn1, dn3;
  res_t        r1, r3, h1, h3;
  logic [31:0] busy_vec1;
  logic [79:0] obs_slots;
  logic [2:0]  sel_end1;

  // Reference: scan enabled CFEBs in ascending order, keep strictly better rank.
  function automatic res_t model(input logic [6:0] mask);
    logic [6:0] bp;
    logic [2:0] bc;
    logic [4:0] bk;
    bp = 7'd0; bc = 3'd0; bk = 5'd0;
    for (int c = 0; c < 7; c++) begin
      if (mask[c] && (tab_pat[c][6:1] > bp[6:1])) begin
        bp = tab_pat[c];
        bc = 3'(c);
        bk = tab_key[c];
      end
    end
    return {(bp[6:1] != 6'd0), bp, bc, bc, bk};
  endfunction

  function automatic int exp_lat(input logic [6:0] mask, input int lat);
    int n;
    n = $countones(mask);
    return (n == 0) ? 1 : n + lat;
  endfunction

  function automatic logic [79:0] exp_slots(input logic [6:0] mask);
    logic [79:0] s;
    int i;
    s = '0;
    i = 0;
    for (int c = 0; c < 7; c++) begin
      if (mask[c]) begin
        s[i*4 +: 4] = {1'b1, 3'(c)};
        i++;
      end
    end
    return s;
  endfunction

  function automatic logic [2:0] last_en(input logic [6:0] mask);
    logic [2:0] l;
    l = 3'd0;
    for (int c = 0; c < 7; c++) if (mask[c]) l = 3'(c);
    return l;
  endfunction

  // Pulse start, then observe WIN clocks (k = clock after edge E_k).
  task automatic run_scan(input logic [6:0] mask, input bit repulse);
    int l1;
    l1 = exp_lat(mask, 1);
    @(negedge clock);
    start   = 1'b1;
    cfeb_en = mask;
    @(negedge clock);
    start = 1'b0;
    dk1 = -1; dk3 = -1; dn1 = 0; dn3 = 0;
    r1 = '0; r3 = '0; busy_vec1 = '0; obs_slots = '0;
    for (int k = 0; k < WIN; k++) begin
      if (done1) begin
        dn1++;
        if (dk1 < 0) begin dk1 = k; r1 = {bvld1, bpat1, bcfeb1, bhs1}; end
      end
      if (done3) begin
        dn3++;
        if (dk3 < 0) begin dk3 = k; r3 = {bvld3, bpat3, bcfeb3, bhs3}; end
      end
      busy_vec1[k] = busy1;
      if (svld1) obs_slots[k*4 +: 4] = {1'b1, sel1};
      cfeb_en = 7'($urandom);
      start   = repulse && ((k == 1) || (k == l1));
      @(negedge clock);
    end
    start    = 1'b0;
    h1       = {bvld1, bpat1, bcfeb1, bhs1};
    h3       = {bvld3, bpat3, bcfeb3, bhs3};
    sel_end1 = sel1;
  endtask

  task automatic clear_tab();
    for (int c = 0; c < 7; c++) begin
      tab_pat[c] = 7'd0;
      tab_key[c] = 5'($urandom);
    end
  endtask

  task automatic test_reset();
    logic [31:0] o1, o3;
    clear_tab();
    reset_n = 1'b0;
    #1;
    o1 = {sel1, svld1, busy1, done1, bvld1, bpat1, bhs1, bcfeb1};
    o3 = {sel3, svld3, busy3, done3, bvld3, bpat3, bhs3, bcfeb3};
    checks++;
    if (o1 !== 32'd0) begin errors++; $display("FAIL reset_outputs_lat1: got %h expected 0", o1); end
    checks++;
    if (o3 !== 32'd0) begin errors++; $display("FAIL reset_outputs_lat3: got %h expected 0", o3); end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_single_best();
    res_t e;
    clear_tab();
    tab_pat[3] = 7'h62;
    tab_key[3] = 5'd5;
    e = {1'b1, 7'h62, 3'd3, 8'd101};
    run_scan(7'h7F, 1'b0);
    checks++;
    if (dk1 != 8) begin errors++; $display("FAIL single_done_time_lat1: got %0d expected 8", dk1); end
    checks++;
    if (dk3 != 10) begin errors++; $display("FAIL single_done_time_lat3: got %0d expected 10", dk3); end
    checks++;
    if (r1 !== e) begin errors++; $display("FAIL single_result_lat1: got %h expected %h", r1, e); end
    checks++;
    if (r3 !== e) begin errors++; $display("FAIL single_result_lat3: got %h expected %h", r3, e); end
    checks++;
    if (dn1 != 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", dn1); end
  endtask

  task automatic test_ties();
    logic [6:0] p2 [4];
    logic [6:0] p5 [4];
    logic [2:0] wc [4];
    res_t e;
    p2 = '{7'h52, 7'h53, 7'h52, 7'h52};
    p5 = '{7'h52, 7'h52, 7'h54, 7'h53};
    wc = '{3'd2, 3'd2, 3'd5, 3'd2};
    for (int t = 0; t < 4; t++) begin
      clear_tab();
      tab_pat[2] = p2[t];
      tab_pat[5] = p5[t];
      e = {1'b1, tab_pat[wc[t]], wc[t], wc[t], tab_key[wc[t]]};
      run_scan(7'h7F, 1'b0);
      checks++;
      if (r1 !== e) begin errors++; $display("FAIL tie_case%0d_lat1: got %h expected %h", t, r1, e); end
      checks++;
      if (r3 !== e) begin errors++; $display("FAIL tie_case%0d_lat3: got %h expected %h", t, r3, e); end
    end
  endtask

  task automatic test_sparse_mask();
    res_t e;
    logic [79:0] es;
    clear_tab();
    tab_pat[0] = 7'h21;
    tab_pat[2] = 7'h30;
    tab_pat[4] = 7'h7E;
    tab_pat[6] = 7'h25;
    e  = {1'b1, 7'h30, 3'd2, 3'd2, tab_key[2]};
    es = '0;
    es[11:0] = {4'hE, 4'hA, 4'h8};
    run_scan(7'b1000101, 1'b0);
    checks++;
    if (obs_slots !== es) begin errors++; $display("FAIL sparse_sel_sequence: got %h expected %h", obs_slots, es); end
    checks++;
    if (dk1 != 4) begin errors++; $display("FAIL sparse_done_time_lat1: got %0d expected 4", dk1); end
    checks++;
    if (dk3 != 6) begin errors++; $display("FAIL sparse_done_time_lat3: got %0d expected 6", dk3); end
    checks++;
    if (r1 !== e) begin errors++; $display("FAIL sparse_result: got %h expected %h", r1, e); end
    checks++;
    if (busy_vec1 !== 32'hF) begin errors++; $display("FAIL sparse_busy: got %h expected f", busy_vec1); end
    checks++;
    if (sel_end1 !== 3'd6) begin errors++; $display("FAIL sparse_sel_hold: got %0d expected 6", sel_end1); end
  endtask

  task automatic test_empty();
    for (int c = 0; c < 7; c++) begin
      tab_pat[c] = 7'h7E;
      tab_key[c] = 5'($urandom);
    end
    run_scan(7'h00, 1'b0);
    checks++;
    if (dk1 != 1) begin errors++; $display("FAIL empty_mask_done_lat1: got %0d expected 1", dk1); end
    checks++;
    if (dk3 != 1) begin errors++; $display("FAIL empty_mask_done_lat3: got %0d expected 1", dk3); end
    checks++;
    if (r1 !== '0) begin errors++; $display("FAIL empty_mask_result: got %h expected 0", r1); end
    checks++;
    if (busy_vec1 !== 32'h1) begin errors++; $display("FAIL empty_mask_busy: got %h expected 1", busy_vec1); end
    checks++;
    if (obs_slots !== '0) begin errors++; $display("FAIL empty_mask_issues: got %h expected 0", obs_slots); end
    for (int c = 0; c < 7; c++) tab_pat[c] = 7'(c & 1);
    run_scan(7'h7F, 1'b0);
    checks++;
    if (r1 !== '0) begin errors++; $display("FAIL zero_pats_result_lat1: got %h expected 0", r1); end
    checks++;
    if (r3 !== '0) begin errors++; $display("FAIL zero_pats_result_lat3: got %h expected 0", r3); end
    checks++;
    if (dk1 != 8) begin errors++; $display("FAIL zero_pats_done_time: got %0d expected 8", dk1); end
  endtask

  task automatic test_restart_ignored();
    res_t e;
    for (int c = 0; c < 7; c++) begin
      tab_pat[c] = 7'($urandom);
      tab_key[c] = 5'($urandom);
    end
    e = model(7'h7F);
    run_scan(7'h7F, 1'b1);
    checks++;
    if (dn1 != 1) begin errors++; $display("FAIL restart_done_count_lat1: got %0d expected 1", dn1); end
    checks++;
    if (dn3 != 1) begin errors++; $display("FAIL restart_done_count_lat3: got %0d expected 1", dn3); end
    checks++;
    if (dk1 != 8) begin errors++; $display("FAIL restart_done_time: got %0d expected 8", dk1); end
    checks++;
    if (r1 !== e) begin errors++; $display("FAIL restart_result: got %h expected %h", r1, e); end
  endtask

  task automatic test_reset_mid_drain();
    logic [31:0] o1, o3;
    int nd;
    res_t e;
    clear_tab();
    tab_pat[3] = 7'h62;
    @(negedge clock);
    start   = 1'b1;
    cfeb_en = 7'h7F;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    reset_n = 1'b0;
    #1;
    o1 = {sel1, svld1, busy1, done1, bvld1, bpat1, bhs1, bcfeb1};
    o3 = {sel3, svld3, busy3, done3, bvld3, bpat3, bhs3, bcfeb3};
    checks++;
    if (o1 !== 32'd0) begin errors++; $display("FAIL midscan_reset_lat1: got %h expected 0", o1); end
    checks++;
    if (o3 !== 32'd0) begin errors++; $display("FAIL midscan_reset_lat3: got %h expected 0", o3); end
    @(negedge clock);
    reset_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (done1 || done3) nd++;
    end
    checks++;
    if (nd != 0) begin errors++; $display("FAIL midscan_reset_no_done: got %0d expected 0", nd); end
    tab_pat[5] = 7'h44;
    e = model(7'h7F);
    run_scan(7'h7F, 1'b0);
    checks++;
    if (r1 !== e || dk1 != 8) begin
      errors++;
      $display("FAIL after_reset_scan: got %h at %0d expected %h at 8", r1, dk1, e);
    end
  endtask

  task automatic test_random();
    logic [6:0]  mask;
    res_t        e;
    logic [79:0] es;
    logic [31:0] eb;
    int          l1, l3;
    logic [6:0]  pool [4];
    pool = '{7'h00, 7'h01, 7'h52, 7'h53};
    for (int it = 0; it < 25; it++) begin
      mask = 7'($urandom);
      for (int c = 0; c < 7; c++) begin
        tab_pat[c] = ($urandom_range(0, 2) == 0) ? 7'($urandom) : pool[$urandom_range(0, 3)];
        tab_key[c] = 5'($urandom);
      end
      e  = model(mask);
      es = exp_slots(mask);
      l1 = exp_lat(mask, 1);
      l3 = exp_lat(mask, 3);
      eb = (32'd1 << l1) - 32'd1;
      run_scan(mask, 1'b0);
      checks++;
      if (dk1 != l1) begin errors++; $display("FAIL rand%0d_done_lat1: got %0d expected %0d", it, dk1, l1); end
      checks++;
      if (dk3 != l3) begin errors++; $display("FAIL rand%0d_done_lat3: got %0d expected %0d", it, dk3, l3); end
      checks++;
      if (r1 !== e) begin errors++; $display("FAIL rand%0d_result_lat1: got %h expected %h", it, r1, e); end
      checks++;
      if (r3 !== e) begin errors++; $display("FAIL rand%0d_result_lat3: got %h expected %h", it, r3, e); end
      checks++;
      if (h1 !== e || h3 !== e) begin
        errors++;
        $display("FAIL rand%0d_result_held: got %h/%h expected %h", it, h1, h3, e);
      end
      checks++;
      if (obs_slots !== es) begin errors++; $display("FAIL rand%0d_sel_sequence: got %h expected %h", it, obs_slots, es); end
      checks++;
      if (busy_vec1 !== eb) begin errors++; $display("FAIL rand%0d_busy: got %h expected %h", it, busy_vec1, eb); end
      if (mask != 7'd0) begin
        checks++;
        if (sel_end1 !== last_en(mask)) begin
          errors++;
          $display("FAIL rand%0d_sel_hold: got %0d expected %0d", it, sel_end1, last_en(mask));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_best();
    test_ties();
    test_sparse_mask();
    test_empty();
    test_restart_ignored();
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
